lcd_bus_responder: RTL and testbench

- Device-side responder for the HD44780-style 2x16 character LCD bus that our printer/controller pair drives.
- Decodes writes on LCD_DATA/LCD_RS/LCD_RW/LCD_EN and maintains a mirror of the visible DDRAM (two 16-byte lines) plus display-control state.
- Used as a synthesizable display model in simulation. Also used as an on-chip sniffer that feeds the mirrored text to VGA/UART overlays.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_bus_responder_if.sv | 10 +
 rtl/lcd_bus_sync.sv | 59 +++++
 rtl/lcd_bus_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared opcodes, DDRAM layout constants and AC helpers for the LCD responder
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;
  localparam logic [7:0] LCD_SPACE  = 8'h20;

  typedef logic [LINE_LEN-1:0][7:0] lcd_line_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} lcd_state_t;

  // Two-line address counter: 0x00-0x27 and 0x40-0x67 form one ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == 7'h27) return LINE1_BASE;
      if (ac == 7'h67) return LINE0_BASE;
      return ac + 7'd1;
    end
    if (ac == 7'h00) return 7'h67;
    if (ac == 7'h40) return 7'h27;
    return ac - 7'd1;
  endfunction

  function automatic logic [6:0] ac_clamp(input logic [6:0] v);
    if ((v >= 7'h28 && v <= 7'h3F) || v >= 7'h68) return LINE0_BASE;
    return v;
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// rtl/lcd_bus_responder_if.sv - HD44780-style LCD pin bundle; the controller drives, the responder listens
interface lcd_bus_responder_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (output LCD_DATA, output LCD_RW, output LCD_EN, output LCD_RS);
  modport slave  (input  LCD_DATA, input  LCD_RW, input  LCD_EN, input  LCD_RS);
endinterface

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - pin synchronizers, capture register and registered EN falling-edge event
module lcd_bus_sync (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_responder_if.slave  bus,
  output logic                ev_valid,
  output logic                ev_rs,
  output logic                ev_rw,
  output logic [7:0]          ev_data
);

  logic       en_s1_q, en_s2_q, en_prev_q;
  logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       cap_rs_q, cap_rw_q;
  logic [7:0] cap_data_q;
  logic       ev_valid_q;

  // The event is registered once more so the decoder acts three edges after EN is seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      en_prev_q  <= 1'b0;
      rs_s1_q    <= 1'b0;
      rs_s2_q    <= 1'b0;
      rw_s1_q    <= 1'b0;
      rw_s2_q    <= 1'b0;
      data_s1_q  <= 8'h00;
      data_s2_q  <= 8'h00;
      cap_rs_q   <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_data_q <= 8'h00;
      ev_valid_q <= 1'b0;
    end else begin
      en_s1_q    <= bus.LCD_EN;
      en_s2_q    <= en_s1_q;
      en_prev_q  <= en_s2_q;
      rs_s1_q    <= bus.LCD_RS;
      rs_s2_q    <= rs_s1_q;
      rw_s1_q    <= bus.LCD_RW;
      rw_s2_q    <= rw_s1_q;
      data_s1_q  <= bus.LCD_DATA;
      data_s2_q  <= data_s1_q;
      ev_valid_q <= en_prev_q & ~en_s2_q;
      if (en_s2_q) begin
        cap_rs_q   <= rs_s2_q;
        cap_rw_q   <= rw_s2_q;
        cap_data_q <= data_s2_q;
      end
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_rs    = cap_rs_q;
  assign ev_rw    = cap_rw_q;
  assign ev_data  = cap_data_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780 write decoder keeping a 2x16 DDRAM mirror, display flags and busy model
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_MZ = 50,
  parameter int EXEC_US     = 40,
  parameter int CLEAR_US    = 1640
) (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_responder_if.slave  bus,
  output lcd_line_t           line0,
  output lcd_line_t           line1,
  output logic                display_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic [6:0]          cursor_addr,
  output logic                busy,
  output logic                update,
  output logic [15:0]         overrun_cnt,
  output logic                unsupported
);

  localparam int EXEC_LOAD  = CLK_FREQ_MZ * EXEC_US;
  localparam int CLEAR_LOAD = CLK_FREQ_MZ * CLEAR_US;
  localparam int MAX_LOAD   = (CLEAR_LOAD > EXEC_LOAD) ? CLEAR_LOAD : EXEC_LOAD;
  localparam int CNT_W      = $clog2(MAX_LOAD + 1);
  localparam logic [CNT_W-1:0] EXEC_CNT  = CNT_W'(EXEC_LOAD);
  localparam logic [CNT_W-1:0] CLEAR_CNT = CNT_W'(CLEAR_LOAD);

  logic       ev_valid, ev_rs, ev_rw, ev_wr;
  logic [7:0] ev_data;

  lcd_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ev_valid (ev_valid),
    .ev_rs    (ev_rs),
    .ev_rw    (ev_rw),
    .ev_data  (ev_data)
  );

  assign ev_wr = ev_valid & ~ev_rw;

  lcd_state_t       state_q, state_d;
  logic [3:0]       k_q, k_d;
  lcd_line_t        line0_q, line0_d, line1_q, line1_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d, cgram_q, cgram_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update_q, update_d;
  logic [15:0]      overrun_q, overrun_d;
  logic             unsup_q, unsup_d;
  logic             hold_valid_q, hold_valid_d, hold_rs_q, hold_rs_d;
  logic [7:0]       hold_data_q, hold_data_d;

  logic             exec_en, exec_rs;
  logic [7:0]       exec_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      k_q          <= 4'd0;
      line0_q      <= {LINE_LEN{LCD_SPACE}};
      line1_q      <= {LINE_LEN{LCD_SPACE}};
      ac_q         <= LINE0_BASE;
      id_q         <= 1'b1;
      cgram_q      <= 1'b0;
      disp_q       <= 1'b0;
      cur_q        <= 1'b0;
      blink_q      <= 1'b0;
      cnt_q        <= '0;
      update_q     <= 1'b0;
      overrun_q    <= 16'h0000;
      unsup_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_rs_q    <= 1'b0;
      hold_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      line0_q      <= line0_d;
      line1_q      <= line1_d;
      ac_q         <= ac_d;
      id_q         <= id_d;
      cgram_q      <= cgram_d;
      disp_q       <= disp_d;
      cur_q        <= cur_d;
      blink_q      <= blink_d;
      cnt_q        <= cnt_d;
      update_q     <= update_d;
      overrun_q    <= overrun_d;
      unsup_q      <= unsup_d;
      hold_valid_q <= hold_valid_d;
      hold_rs_q    <= hold_rs_d;
      hold_data_q  <= hold_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    line0_d      = line0_q;
    line1_d      = line1_q;
    ac_d         = ac_q;
    id_d         = id_q;
    cgram_d      = cgram_q;
    disp_d       = disp_q;
    cur_d        = cur_q;
    blink_d      = blink_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    update_d     = 1'b0;
    overrun_d    = overrun_q;
    unsup_d      = unsup_q;
    hold_valid_d = hold_valid_q;
    hold_rs_d    = hold_rs_q;
    hold_data_d  = hold_data_q;
    exec_en      = 1'b0;
    exec_rs      = ev_rs;
    exec_data    = ev_data;

    if (ev_valid && ev_rw) unsup_d = 1'b1;
    if (ev_wr && cnt_q != '0 && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        // A write queued during a clear runs first; a coincident new write takes its slot.
        if (hold_valid_q) begin
          exec_en      = 1'b1;
          exec_rs      = hold_rs_q;
          exec_data    = hold_data_q;
          hold_valid_d = ev_wr;
          hold_rs_d    = ev_rs;
          hold_data_d  = ev_data;
        end else begin
          exec_en = ev_wr;
        end
      end
      ST_CLEAR: begin
        line0_d[k_q] = LCD_SPACE;
        line1_d[k_q] = LCD_SPACE;
        k_d          = k_q + 4'd1;
        if (k_q == 4'hF) begin
          state_d  = ST_IDLE;
          ac_d     = LINE0_BASE;
          id_d     = 1'b1;
          cgram_d  = 1'b0;
          update_d = 1'b1;
        end
        if (ev_wr) begin
          hold_valid_d = 1'b1;
          hold_rs_d    = ev_rs;
          hold_data_d  = ev_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (exec_en) begin
      if (exec_rs) begin
        cnt_d = EXEC_CNT;
        if (cgram_q) begin
          unsup_d = 1'b1;
        end else begin
          // AC[6:4] selects the visible window: 000 -> line 0, 100 -> line 1, else off-screen.
          if (ac_q[6:4] == 3'b000) begin
            if (line0_q[ac_q[3:0]] != exec_data) begin
              line0_d[ac_q[3:0]] = exec_data;
              update_d           = 1'b1;
            end
          end else if (ac_q[6:4] == 3'b100) begin
            if (line1_q[ac_q[3:0]] != exec_data) begin
              line1_d[ac_q[3:0]] = exec_data;
              update_d           = 1'b1;
            end
          end
          ac_d = ac_step(ac_q, id_q);
        end
      end else if (exec_data >= CMD_DDRAM) begin
        cnt_d   = EXEC_CNT;
        ac_d    = ac_clamp(exec_data[6:0]);
        cgram_d = 1'b0;
      end else if (exec_data >= CMD_CGRAM) begin
        cnt_d   = EXEC_CNT;
        cgram_d = 1'b1;
      end else if (exec_data >= CMD_FUNC) begin
        cnt_d = EXEC_CNT;
        if (!exec_data[4]) unsup_d = 1'b1;
      end else if (exec_data >= CMD_SHIFT) begin
        cnt_d = EXEC_CNT;
        if (exec_data[3]) unsup_d = 1'b1;
        else              ac_d    = ac_step(ac_q, exec_data[2]);
      end else if (exec_data >= CMD_DISPCTL) begin
        cnt_d   = EXEC_CNT;
        disp_d  = exec_data[2];
        cur_d   = exec_data[1];
        blink_d = exec_data[0];
      end else if (exec_data >= CMD_ENTRY) begin
        cnt_d = EXEC_CNT;
        id_d  = exec_data[1];
        if (exec_data[0]) unsup_d = 1'b1;
      end else if (exec_data >= CMD_HOME) begin
        cnt_d = CLEAR_CNT;
        ac_d  = LINE0_BASE;
      end else if (exec_data == CMD_CLEAR) begin
        cnt_d   = CLEAR_CNT;
        state_d = ST_CLEAR;
        k_d     = 4'd0;
      end
    end
  end

  assign line0       = line0_q;
  assign line1       = line1_q;
  assign display_on  = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign cursor_addr = ac_q;
  assign busy        = (cnt_q != '0);
  assign update      = update_q;
  assign overrun_cnt = overrun_q;
  assign unsupported = unsup_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - directed scenario bench for lcd_bus_responder
module tb_lcd_bus_responder;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  lcd_line_t   line0, line1;
  logic        display_on, cursor_on, blink_on, busy, update, unsupported;
  logic [6:0]  cursor_addr;
  logic [15:0] overrun_cnt;
  int          tests = 0;
  int          fails = 0;
  lcd_line_t   exp0, exp1;

  always #5 clk = ~clk;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.CLK_FREQ_MZ(1), .EXEC_US(30), .CLEAR_US(100)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .line0(line0), .line1(line1),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cursor_addr(cursor_addr), .busy(busy), .update(update),
    .overrun_cnt(overrun_cnt), .unsupported(unsupported)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_DATA = d;
    @(negedge clk);
    bus.LCD_EN = 1'b1;
    repeat (4) @(negedge clk);
    bus.LCD_EN = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    repeat (5) @(negedge clk);
    while (busy && n < 1000) begin @(negedge clk); n++; end
    tests++;
    if (busy) begin fails++; $display("FAIL busy_timeout: busy=%b required 0", busy); end
  endtask

  task automatic cmd(input logic [7:0] d); bus_cycle(1'b0, 1'b0, d); wait_idle(); endtask
  task automatic dat(input logic [7:0] d); bus_cycle(1'b1, 1'b0, d); wait_idle(); endtask

  task automatic do_reset;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    exp0 = {LINE_LEN{8'h20}};
    tests++;
    if (line0 !== exp0 || line1 !== exp0) begin fails++; $display("FAIL reset_lines: l0=%h l1=%h required all 20", line0, line1); end
    tests++;
    if ({display_on, cursor_on, blink_on, busy, update, unsupported} !== 6'b0 || cursor_addr !== 7'h00 || overrun_cnt !== 16'h0) begin
      fails++; $display("FAIL reset_flags: dcb/busy/upd/uns=%b ac=%h ovr=%h required 0", {display_on, cursor_on, blink_on, busy, update, unsupported}, cursor_addr, overrun_cnt);
    end
  endtask

  task automatic test_hello;
    cmd(8'h38); cmd(8'h0C); cmd(8'h01); cmd(8'h06); cmd(8'h80);
    bus_cycle(1'b1, 1'b0, 8'h48);
    repeat (3) @(posedge clk);
    #1 tests++;
    if (update !== 1'b0 || line0[0] !== 8'h20) begin fails++; $display("FAIL latency_early: upd=%b l0[0]=%h required 0/20 at N+2", update, line0[0]); end
    @(posedge clk); #1 tests++;
    if (update !== 1'b1 || line0[0] !== 8'h48) begin fails++; $display("FAIL latency_edge: upd=%b l0[0]=%h required 1/48 at N+3", update, line0[0]); end
    @(posedge clk); #1 tests++;
    if (update !== 1'b0) begin fails++; $display("FAIL update_width: upd=%b required 0 at N+4", update); end
    wait_idle();
    dat(8'h45); dat(8'h4C); dat(8'h4C); dat(8'h4F);
    exp0 = {LINE_LEN{8'h20}};
    exp0[0] = 8'h48; exp0[1] = 8'h45; exp0[2] = 8'h4C; exp0[3] = 8'h4C; exp0[4] = 8'h4F;
    tests++;
    if (line0 !== exp0) begin fails++; $display("FAIL hello_line0: got %h required %h", line0, exp0); end
    tests++;
    if (cursor_addr !== 7'h05 || display_on !== 1'b1 || cursor_on !== 1'b0 || blink_on !== 1'b0) begin
      fails++; $display("FAIL hello_state: ac=%h d=%b c=%b b=%b required 05/1/0/0", cursor_addr, display_on, cursor_on, blink_on);
    end
    tests++;
    if (overrun_cnt !== 16'h0 || unsupported !== 1'b0) begin fails++; $display("FAIL hello_clean: ovr=%h uns=%b required 0/0", overrun_cnt, unsupported); end
  endtask

  task automatic test_line1;
    int ups = 0;
    cmd(8'hC0);
    for (int i = 0; i < 17; i++) dat(8'h41 + 8'(i));
    for (int i = 0; i < 16; i++) exp1[i] = 8'h41 + 8'(i);
    tests++;
    if (line1 !== exp1) begin fails++; $display("FAIL line1_fill: got %h required %h", line1, exp1); end
    tests++;
    if (cursor_addr !== 7'h51 || line0 !== exp0) begin fails++; $display("FAIL line1_ac: ac=%h l0=%h required 51/%h", cursor_addr, line0, exp0); end
    cmd(8'hC0);
    bus_cycle(1'b1, 1'b0, 8'h41);
    repeat (10) begin @(posedge clk); #1 if (update) ups++; end
    wait_idle();
    tests++;
    if (ups !== 0 || cursor_addr !== 7'h41) begin fails++; $display("FAIL same_byte: updates=%0d ac=%h required 0/41", ups, cursor_addr); end
  endtask

  task automatic test_decrement;
    cmd(8'h04); cmd(8'h80); dat(8'h5A);
    exp0[0] = 8'h5A;
    tests++;
    if (line0 !== exp0 || cursor_addr !== 7'h67) begin fails++; $display("FAIL decrement: l0=%h ac=%h required %h/67", line0, cursor_addr, exp0); end
  endtask

  task automatic test_wrap;
    cmd(8'hA7); cmd(8'h14);
    tests++;
    if (cursor_addr !== 7'h40) begin fails++; $display("FAIL wrap_27_inc: ac=%h required 40", cursor_addr); end
    cmd(8'hE7); cmd(8'h14);
    tests++;
    if (cursor_addr !== 7'h00) begin fails++; $display("FAIL wrap_67_inc: ac=%h required 00", cursor_addr); end
    cmd(8'hC0); cmd(8'h10);
    tests++;
    if (cursor_addr !== 7'h27) begin fails++; $display("FAIL wrap_40_dec: ac=%h required 27", cursor_addr); end
    cmd(8'hB0);
    tests++;
    if (cursor_addr !== 7'h00 || unsupported !== 1'b0) begin fails++; $display("FAIL clamp_30: ac=%h uns=%b required 00/0", cursor_addr, unsupported); end
  endtask

  task automatic test_reset_mid_clear;
    int ups = 0;
    logic bad = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h01);
    repeat (11) @(posedge clk);
    #3 reset = 1'b0;
    #1 exp0 = {LINE_LEN{8'h20}};
    tests++;
    if (line0 !== exp0 || line1 !== exp0 || cursor_addr !== 7'h00 || display_on !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midclear_reset: l0=%h l1=%h ac=%h d=%b busy=%b required spaces/00/0/0", line0, line1, cursor_addr, display_on, busy);
    end
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (20) begin @(posedge clk); #1 if (update) ups++; if (line1 !== exp0) bad = 1'b1; end
    tests++;
    if (ups !== 0 || bad) begin fails++; $display("FAIL midclear_quiet: updates=%0d line1_changed=%b required 0/0", ups, bad); end
  endtask

  task automatic test_clear_overrun;
    int ups = 0;
    cmd(8'hCF); dat(8'h7A); cmd(8'h80);
    bus_cycle(1'b0, 1'b0, 8'h01);
    bus_cycle(1'b1, 1'b0, 8'h31);
    repeat (30) begin @(posedge clk); #1 if (update) ups++; end
    wait_idle();
    exp0 = {LINE_LEN{8'h20}};
    exp1 = {LINE_LEN{8'h20}};
    exp0[0] = 8'h31;
    tests++;
    if (line0 !== exp0 || line1 !== exp1) begin fails++; $display("FAIL clear_lines: l0=%h l1=%h required %h/%h", line0, line1, exp0, exp1); end
    tests++;
    if (cursor_addr !== 7'h01 || overrun_cnt !== 16'd1) begin fails++; $display("FAIL clear_queue: ac=%h ovr=%h required 01/0001", cursor_addr, overrun_cnt); end
    tests++;
    if (ups !== 2) begin fails++; $display("FAIL clear_updates: updates=%0d required 2", ups); end
  endtask

  task automatic test_unsupported;
    do_reset();
    cmd(8'h10);
    tests++;
    if (cursor_addr !== 7'h67 || unsupported !== 1'b0) begin fails++; $display("FAIL cursor_shift: ac=%h uns=%b required 67/0", cursor_addr, unsupported); end
    cmd(8'h14); cmd(8'h18);
    tests++;
    if (cursor_addr !== 7'h00 || unsupported !== 1'b1) begin fails++; $display("FAIL display_shift: ac=%h uns=%b required 00/1", cursor_addr, unsupported); end
    do_reset();
    bus_cycle(1'b0, 1'b1, 8'h80);
    wait_idle();
    exp0 = {LINE_LEN{8'h20}};
    tests++;
    if (unsupported !== 1'b1 || cursor_addr !== 7'h00 || line0 !== exp0) begin fails++; $display("FAIL read_cycle: uns=%b ac=%h l0=%h required 1/00/spaces", unsupported, cursor_addr, line0); end
    do_reset();
    cmd(8'h40); dat(8'h55);
    tests++;
    if (unsupported !== 1'b1 || cursor_addr !== 7'h00 || line0 !== exp0) begin fails++; $display("FAIL cgram_data: uns=%b ac=%h l0=%h required 1/00/spaces", unsupported, cursor_addr, line0); end
  endtask

  initial begin
    reset = 1'b0;
    bus.LCD_DATA = 8'h00; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0;
    test_reset();
    test_hello();
    test_line1();
    test_decrement();
    test_wrap();
    test_reset_mid_clear();
    test_clear_overrun();
    test_unsupported();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
